// File: rtl/ms_es_ordered_bs_decoder_if.sv
// Handshake and result bundle between the ordered-bitstream decoder and its driver.
// The master drives the window control and stream lanes; the slave returns counts and status.
interface ms_es_ordered_bs_decoder_if #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
);
    logic                  en;
    logic                  bs_valid;
    logic [NUM_INPUTS-1:0] bs_in;
    logic [DATA_WIDTH:0]   bin_data_out [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] order_err;
    logic                  busy;
    logic                  done;

    modport master (
        output en, bs_valid, bs_in,
        input  bin_data_out, order_err, busy, done
    );

    modport slave (
        input  en, bs_valid, bs_in,
        output bin_data_out, order_err, busy, done
    );
endinterface

// File: rtl/ms_es_ordered_bs_decoder.sv
// Ordered (thermometer) stochastic bitstream to binary decoder: counts ones per lane over a
// 2^DATA_WIDTH-beat window and flags lanes where a 1 follows a 0.
module ms_es_ordered_bs_decoder #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    ms_es_ordered_bs_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [DATA_WIDTH-1:0] BEAT_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] BEAT_LAST = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] BEAT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0]   CNT_ZERO  = {(DATA_WIDTH+1){1'b0}};
    localparam logic [NUM_INPUTS-1:0] LANE_ZERO = {NUM_INPUTS{1'b0}};

    state_t                state_r;
    logic [DATA_WIDTH-1:0] beat_r;
    logic [DATA_WIDTH:0]   cnt_r       [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] seen0_r;
    logic [NUM_INPUTS-1:0] err_r;
    logic [DATA_WIDTH:0]   bin_data_r  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] order_err_r;
    logic                  busy_r;
    logic                  done_r;

    logic [DATA_WIDTH:0]   cnt_nxt_s   [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] seen0_nxt_s;
    logic [NUM_INPUTS-1:0] err_nxt_s;

    // Per-lane accumulator values including the beat currently on bs_in.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_nxt_s[i] = cnt_r[i] + {{DATA_WIDTH{1'b0}}, bus.bs_in[i]};
        end
        seen0_nxt_s = seen0_r | ~bus.bs_in;
        err_nxt_s   = err_r | (bus.bs_in & seen0_r);
    end

    // Window control FSM with accumulators and registered result/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            beat_r      <= BEAT_ZERO;
            seen0_r     <= LANE_ZERO;
            err_r       <= LANE_ZERO;
            order_err_r <= LANE_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_r[i]      <= CNT_ZERO;
                bin_data_r[i] <= CNT_ZERO;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_r  <= BEAT_ZERO;
                    seen0_r <= LANE_ZERO;
                    err_r   <= LANE_ZERO;
                    done_r  <= 1'b0;
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        cnt_r[i] <= CNT_ZERO;
                    end
                    if (bus.en) begin
                        state_r <= ST_COUNT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    done_r <= 1'b0;
                    // Dropping en aborts even on the final beat; outputs keep the last good window.
                    if (!bus.en) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        beat_r  <= BEAT_ZERO;
                        seen0_r <= LANE_ZERO;
                        err_r   <= LANE_ZERO;
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            cnt_r[i] <= CNT_ZERO;
                        end
                    end else if (bus.bs_valid) begin
                        if (beat_r == BEAT_LAST) begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            bin_data_r  <= cnt_nxt_s;
                            order_err_r <= err_nxt_s;
                        end else begin
                            state_r <= ST_COUNT;
                            busy_r  <= 1'b1;
                            beat_r  <= beat_r + BEAT_ONE;
                            cnt_r   <= cnt_nxt_s;
                            seen0_r <= seen0_nxt_s;
                            err_r   <= err_nxt_s;
                        end
                    end else begin
                        state_r <= ST_COUNT;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_out
        assign bus.bin_data_out[g] = bin_data_r[g];
    end

    assign bus.order_err = order_err_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_ms_es_ordered_bs_decoder.sv
// Directed self-checking bench for the ordered-bitstream decoder (DATA_WIDTH=5, NUM_INPUTS=2).
module tb_ms_es_ordered_bs_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_seen;
    int   lat;
    int   early;
    int   done_before;

    ms_es_ordered_bs_decoder_if #(.DATA_WIDTH(5), .NUM_INPUTS(2)) bus ();

    ms_es_ordered_bs_decoder #(.DATA_WIDTH(5), .NUM_INPUTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int b0, input int b1, input int oe);
        check({tag, "_bin0"}, 32'(bus.bin_data_out[0]), b0);
        check({tag, "_bin1"}, 32'(bus.bin_data_out[1]), b1);
        check({tag, "_err"}, 32'(bus.order_err), oe);
    endtask

    // Beat j of lane k comes from bit j of lk; bub[j] inserts an invalid cycle (bs_in=11) before beat j.
    task automatic run_window(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] bub,
                              input int abort_at, output int lat_o, output int early_o);
        lat_o = 0;
        early_o = 0;
        bus.en = 1'b1;
        bus.bs_valid = 1'b0;
        bus.bs_in = 2'b00;
        step();
        lat_o++;
        for (int j = 0; j < 32; j++) begin
            if (bub[j]) begin
                bus.bs_valid = 1'b0;
                bus.bs_in = 2'b11;
                step();
                lat_o++;
                if (bus.done === 1'b1) early_o++;
            end
            if (j == abort_at) bus.en = 1'b0;
            bus.bs_valid = 1'b1;
            bus.bs_in = {l1[j], l0[j]};
            step();
            lat_o++;
            if (j == abort_at) begin
                bus.bs_valid = 1'b0;
                bus.bs_in = 2'b00;
                return;
            end
            if (j < 31 && bus.done === 1'b1) early_o++;
        end
        bus.bs_valid = 1'b0;
        bus.bs_in = 2'b00;
        bus.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_seen = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.bs_valid = 1'b0;
        bus.bs_in = 2'b00;
        step();
        step();
        check_outs("reset", 0, 0, 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        rst = 1'b1;
        step();

        // Basic decode: lane0 20 ones then zeros, lane1 zeros.
        run_window(32'h000F_FFFF, 32'h0000_0000, 32'h0, -1, lat, early);
        check("basic_done", 32'(bus.done), 1);
        check("basic_busy", 32'(bus.busy), 0);
        check("basic_lat", lat, 33);
        check("basic_early", early, 0);
        check_outs("basic", 20, 0, 0);
        step();
        check("basic_done_pulse", 32'(bus.done), 0);

        // Full-scale lane1, single one on lane0.
        run_window(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, -1, lat, early);
        check("full_done", 32'(bus.done), 1);
        check_outs("full", 1, 32, 0);
        step();

        // Ten bubbles with bs_in=11 between valid beats.
        run_window(32'h0000_00FF, 32'hFFFF_FFFF, 32'h000A_AAAA, -1, lat, early);
        check("bub_done", 32'(bus.done), 1);
        check("bub_lat", lat, 43);
        check("bub_early", early, 0);
        check_outs("bub", 8, 32, 0);
        step();

        // Alternating lane0 violates ordering.
        run_window(32'h5555_5555, 32'h0000_FFFF, 32'h0, -1, lat, early);
        check("order_done", 32'(bus.done), 1);
        check_outs("order", 16, 16, 1);
        step();

        run_window(32'h0000_0007, 32'h0000_0000, 32'h0, -1, lat, early);
        check("clean_done", 32'(bus.done), 1);
        check_outs("clean", 3, 0, 0);
        step();

        // Abort at beat 10: no done, outputs held.
        done_before = done_seen;
        run_window(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 10, lat, early);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        step();
        check("abort_no_done", done_seen - done_before, 0);
        check_outs("abort_hold", 3, 0, 0);

        run_window(32'h0000_001F, 32'h0000_0003, 32'h0, -1, lat, early);
        check("restart_done", 32'(bus.done), 1);
        check("restart_lat", lat, 33);
        check_outs("restart", 5, 2, 0);
        step();

        // en dropped on the final valid beat takes priority over completion.
        done_before = done_seen;
        run_window(32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 31, lat, early);
        check("lastabort_done", 32'(bus.done), 0);
        check("lastabort_busy", 32'(bus.busy), 0);
        step();
        check("lastabort_no_done", done_seen - done_before, 0);
        check_outs("lastabort_hold", 5, 2, 0);

        // Asynchronous reset mid-window clears outputs before the next edge.
        bus.en = 1'b1;
        step();
        bus.bs_valid = 1'b1;
        bus.bs_in = 2'b11;
        for (int j = 0; j < 5; j++) step();
        check("mid_busy_pre", 32'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        bus.en = 1'b0;
        bus.bs_valid = 1'b0;
        bus.bs_in = 2'b00;
        step();
        rst = 1'b1;
        done_before = done_seen;
        for (int j = 0; j < 40; j++) step();
        check("midrst_no_done", done_seen - done_before, 0);
        check("midrst_idle_busy", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
